// File: rtl/uart_cmd_pkg.sv
// Package: uart_cmd_pkg
// Shared types and ASCII constants for the UART command parser.
//  cmd_e   : 2-bit command encoding carried in o_word[DATA_W+1:DATA_W]
//  err_e   : error codes reported on o_err_code
//  state_e : parser FSM states
//  cls_e   : character classes produced by uart_ascii_classify
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_RD   = 2'd0,
    CMD_WR   = 2'd1,
    CMD_ADDR = 2'd2,
    CMD_SPEC = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_NOCMD   = 2'd0,
    ERR_LONG    = 2'd1,
    ERR_OVERRUN = 2'd2,
    ERR_RESTART = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_CMD   = 2'd1,
    CLS_HEX   = 2'd2,
    CLS_TERM  = 2'd3
  } cls_e;

  localparam logic [6:0] ASC_R    = 7'h52;
  localparam logic [6:0] ASC_W    = 7'h57;
  localparam logic [6:0] ASC_A    = 7'h41;
  localparam logic [6:0] ASC_S    = 7'h53;
  localparam logic [6:0] ASC_E    = 7'h45;
  localparam logic [6:0] ASC_LF   = 7'h0A;
  localparam logic [6:0] ASC_CR   = 7'h0D;
  localparam logic [6:0] ASC_0    = 7'h30;
  localparam logic [6:0] ASC_9    = 7'h39;
  localparam logic [6:0] ASC_LC_A = 7'h61;
  localparam logic [6:0] ASC_LC_F = 7'h66;

endpackage

// File: rtl/uart_ascii_classify.sv
// Module: uart_ascii_classify
// Purely combinational decode of a 7-bit ASCII character.
//  i_data   in  7  character code
//  o_class  out 2  cls_e: OTHER / CMD / HEX / TERM
//  o_nibble out 4  hex value, meaningful when o_class == CLS_HEX
//  o_cmd    out 2  cmd_e, meaningful when o_class == CLS_CMD
// TERM_NL=1 adds LF and CR to the terminator set alongside 'E'.
module uart_ascii_classify
  import uart_cmd_pkg::*;
#(
  parameter bit TERM_NL = 1'b1
) (
  input  logic [6:0] i_data,
  output logic [1:0] o_class,
  output logic [3:0] o_nibble,
  output logic [1:0] o_cmd
);

  always_comb begin
    o_class  = CLS_OTHER;
    o_nibble = 4'd0;
    o_cmd    = CMD_RD;
    if (i_data == ASC_R) begin
      o_class = CLS_CMD;
      o_cmd   = CMD_RD;
    end else if (i_data == ASC_W) begin
      o_class = CLS_CMD;
      o_cmd   = CMD_WR;
    end else if (i_data == ASC_A) begin
      o_class = CLS_CMD;
      o_cmd   = CMD_ADDR;
    end else if (i_data == ASC_S) begin
      o_class = CLS_CMD;
      o_cmd   = CMD_SPEC;
    end else if (i_data == ASC_E) begin
      o_class = CLS_TERM;
    end else if (TERM_NL && (i_data == ASC_LF || i_data == ASC_CR)) begin
      o_class = CLS_TERM;
    end else if (i_data >= ASC_0 && i_data <= ASC_9) begin
      o_class  = CLS_HEX;
      o_nibble = i_data[3:0];
    end else if (i_data >= ASC_LC_A && i_data <= ASC_LC_F) begin
      // 'a' is 0x61: low nibble 1 maps to 10
      o_class  = CLS_HEX;
      o_nibble = i_data[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Module: uart_cmd_parser
// Parses "<cmd><hex digits><term>" from a UART byte stream into
// {cmd, value} words with a ready/valid output handshake.
//  i_clk, i_rst_n : clock, asynchronous active-low reset
//  i_data, i_stb  : incoming byte and its one-cycle strobe
//  o_stb, i_ready : output word valid / accepted
//  o_word         : {cmd[1:0], value[DATA_W-1:0]}
//  o_ndigits      : number of hex digits that built o_word
//  o_err          : one-cycle error pulse, cause in o_err_code
// All outputs are registers; i_data/i_stb/i_ready only feed next-state logic.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = DATA_W / 4,
  parameter bit TERM_NL    = 1'b1,
  localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_data,
  input  logic              i_stb,
  output logic              o_stb,
  input  logic              i_ready,
  output logic [DATA_W+1:0] o_word,
  output logic [CNT_W-1:0]  o_ndigits,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  state_e              r_state, w_state_next;
  logic [1:0]          r_cmd, w_cmd_next;
  logic [DATA_W-1:0]   r_value, w_value_next;
  logic [CNT_W-1:0]    r_count, w_count_next;
  logic [DATA_W+1:0]   r_word, w_word_next;
  logic [CNT_W-1:0]    r_ndigits, w_ndigits_next;
  logic                r_stb, w_stb_next;
  logic                r_err, w_err_next;
  logic [1:0]          r_err_code, w_err_code_next;

  logic [1:0]          w_class;
  logic [3:0]          w_nibble;
  logic [1:0]          w_cmd;
  logic [DATA_W+3:0]   w_shifted;
  logic                w_unused_bit7;

  assign w_unused_bit7 = i_data[7];

  uart_ascii_classify #(.TERM_NL(TERM_NL)) u_classify (
    .i_data   (i_data[6:0]),
    .o_class  (w_class),
    .o_nibble (w_nibble),
    .o_cmd    (w_cmd)
  );

  // Shift through a widened vector so the expression stays legal for DATA_W=4
  assign w_shifted = {r_value, w_nibble};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd      <= 2'd0;
      r_value    <= '0;
      r_count    <= '0;
      r_word     <= '0;
      r_ndigits  <= '0;
      r_stb      <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_cmd      <= w_cmd_next;
      r_value    <= w_value_next;
      r_count    <= w_count_next;
      r_word     <= w_word_next;
      r_ndigits  <= w_ndigits_next;
      r_stb      <= w_stb_next;
      r_err      <= w_err_next;
      r_err_code <= w_err_code_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cmd_next      = r_cmd;
    w_value_next    = r_value;
    w_count_next    = r_count;
    w_word_next     = r_word;
    w_ndigits_next  = r_ndigits;
    w_stb_next      = r_stb;
    w_err_next      = 1'b0;
    w_err_code_next = r_err_code;
    case (r_state)
      ST_IDLE: begin
        if (i_stb) begin
          if (w_class == CLS_CMD) begin
            w_cmd_next   = w_cmd;
            w_value_next = '0;
            w_count_next = '0;
            w_state_next = ST_COLLECT;
          end else if (w_class == CLS_HEX || w_class == CLS_TERM) begin
            w_err_next      = 1'b1;
            w_err_code_next = ERR_NOCMD;
          end
        end
      end
      ST_COLLECT: begin
        if (i_stb) begin
          if (w_class == CLS_HEX) begin
            if (r_count == MAX_CNT) begin
              w_err_next      = 1'b1;
              w_err_code_next = ERR_LONG;
              w_value_next    = '0;
              w_count_next    = '0;
              w_state_next    = ST_IDLE;
            end else begin
              w_value_next = w_shifted[DATA_W-1:0];
              w_count_next = r_count + 1'b1;
            end
          end else if (w_class == CLS_CMD) begin
            // New command aborts the partial one and starts over
            w_err_next      = 1'b1;
            w_err_code_next = ERR_RESTART;
            w_cmd_next      = w_cmd;
            w_value_next    = '0;
            w_count_next    = '0;
          end else if (w_class == CLS_TERM) begin
            w_word_next    = {r_cmd, r_value};
            w_ndigits_next = r_count;
            w_stb_next     = 1'b1;
            w_state_next   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (r_stb && i_ready) begin
          w_stb_next   = 1'b0;
          w_state_next = ST_IDLE;
        end
        // Bytes arriving while a word is pending are lost, even on the handshake cycle
        if (i_stb) begin
          w_err_next      = 1'b1;
          w_err_code_next = ERR_OVERRUN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_stb_next   = 1'b0;
      end
    endcase
  end

  assign o_stb      = r_stb;
  assign o_word     = r_word;
  assign o_ndigits  = r_ndigits;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser (DATA_W=32, TERM_NL=1).
module tb_uart_cmd_parser;

  logic        clk;
  logic        i_rst_n;
  logic [7:0]  i_data;
  logic        i_stb;
  logic        o_stb;
  logic        i_ready;
  logic [33:0] o_word;
  logic [3:0]  o_ndigits;
  logic        o_err;
  logic [1:0]  o_err_code;

  int n_total  = 0;
  int n_pass   = 0;
  int n_accept = 0;

  uart_cmd_parser #(.DATA_W(32), .TERM_NL(1'b1)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_data     (i_data),
    .i_stb      (i_stb),
    .o_stb      (o_stb),
    .i_ready    (i_ready),
    .o_word     (o_word),
    .o_ndigits  (o_ndigits),
    .o_err      (o_err),
    .o_err_code (o_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i_rst_n && o_stb && i_ready) n_accept++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Byte is sampled at the posedge inside; on return (next negedge) its effect is visible
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    i_data = b;
    i_stb  = 1'b1;
    @(negedge clk);
    i_stb  = 1'b0;
    i_data = 8'h00;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_data  = 8'h00;
    i_stb   = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stb", {63'd0, o_stb}, 64'd0);
    chk("rst_word", {30'd0, o_word}, 64'd0);
    chk("rst_ndig", {60'd0, o_ndigits}, 64'd0);
    chk("rst_err", {63'd0, o_err}, 64'd0);
    chk("rst_code", {62'd0, o_err_code}, 64'd0);
    i_rst_n = 1'b1;

    // 1: "A1fE"
    send("A"); send("1"); send("f");
    chk("t1_nostb_before_term", {63'd0, o_stb}, 64'd0);
    send("E");
    chk("t1_stb", {63'd0, o_stb}, 64'd1);
    chk("t1_word", {30'd0, o_word}, {30'd0, 2'b10, 32'h0000001F});
    chk("t1_ndig", {60'd0, o_ndigits}, 64'd2);
    @(negedge clk);
    chk("t1_stb_fall", {63'd0, o_stb}, 64'd0);
    chk("t1_accepts", 64'(n_accept), 64'd1);
    $display("t1 A1fE done");

    // 2: "W12345678\n" with i_ready low for 5 cycles
    i_ready = 1'b0;
    send("W"); send("1"); send("2"); send("3"); send("4");
    send("5"); send("6"); send("7"); send("8"); send(8'h0A);
    for (int k = 0; k < 5; k++) begin
      chk("t2_stb_held", {63'd0, o_stb}, 64'd1);
      chk("t2_word", {30'd0, o_word}, {30'd0, 2'b01, 32'h12345678});
      @(negedge clk);
    end
    i_ready = 1'b1;
    chk("t2_stb_6th", {63'd0, o_stb}, 64'd1);
    chk("t2_ndig", {60'd0, o_ndigits}, 64'd8);
    @(negedge clk);
    chk("t2_stb_fall", {63'd0, o_stb}, 64'd0);
    chk("t2_accepts", 64'(n_accept), 64'd2);
    $display("t2 W12345678 backpressure done");

    // 3: "R9" then "A5E"
    send("R"); send("9");
    send("A");
    chk("t3_err", {63'd0, o_err}, 64'd1);
    chk("t3_code_restart", {62'd0, o_err_code}, 64'd3);
    send("5");
    chk("t3_err_pulse", {63'd0, o_err}, 64'd0);
    send("E");
    chk("t3_word", {30'd0, o_word}, {30'd0, 2'b10, 32'h5});
    chk("t3_ndig", {60'd0, o_ndigits}, 64'd1);
    @(negedge clk);
    chk("t3_accepts", 64'(n_accept), 64'd3);
    $display("t3 restart done");

    // 4: "W123456789E"
    send("W"); send("1"); send("2"); send("3"); send("4");
    send("5"); send("6"); send("7"); send("8");
    chk("t4_no_err_8", {63'd0, o_err}, 64'd0);
    send("9");
    chk("t4_err_long", {63'd0, o_err}, 64'd1);
    chk("t4_code_long", {62'd0, o_err_code}, 64'd1);
    send("E");
    chk("t4_err_nocmd", {63'd0, o_err}, 64'd1);
    chk("t4_code_nocmd", {62'd0, o_err_code}, 64'd0);
    chk("t4_nostb", {63'd0, o_stb}, 64'd0);
    @(negedge clk);
    chk("t4_accepts", 64'(n_accept), 64'd3);
    $display("t4 too-long done");

    // 5: "RE" held, then byte '3' -> OVERRUN
    i_ready = 1'b0;
    send("R"); send("E");
    chk("t5_stb", {63'd0, o_stb}, 64'd1);
    chk("t5_word", {30'd0, o_word}, 64'd0);
    chk("t5_ndig", {60'd0, o_ndigits}, 64'd0);
    send("3");
    chk("t5_err_overrun", {63'd0, o_err}, 64'd1);
    chk("t5_code_overrun", {62'd0, o_err_code}, 64'd2);
    chk("t5_word_kept", {30'd0, o_word}, 64'd0);
    chk("t5_stb_kept", {63'd0, o_stb}, 64'd1);
    @(negedge clk);
    chk("t5_code_holds", {62'd0, o_err_code}, 64'd2);
    i_ready = 1'b1;
    @(negedge clk);
    chk("t5_accepts", 64'(n_accept), 64'd4);
    $display("t5 overrun done");

    // Handshake and byte in the same cycle: handshake wins, byte dropped
    i_ready = 1'b0;
    send("S"); send("E");
    chk("hs_word", {30'd0, o_word}, {30'd0, 2'b11, 32'h0});
    @(negedge clk);
    i_ready = 1'b1;
    i_data  = "7";
    i_stb   = 1'b1;
    @(negedge clk);
    i_stb   = 1'b0;
    chk("hs_stb_fall", {63'd0, o_stb}, 64'd0);
    chk("hs_err_overrun", {63'd0, o_err}, 64'd1);
    chk("hs_code", {62'd0, o_err_code}, 64'd2);
    send("R"); send("5"); send("E");
    chk("hs_next_word", {30'd0, o_word}, {30'd0, 2'b00, 32'h5});
    @(negedge clk);
    chk("hs_accepts", 64'(n_accept), 64'd6);
    $display("handshake+overrun done");

    // Uppercase hex is ignored; CR terminates
    send("W"); send("F"); send("a"); send(8'h0D);
    chk("uc_word", {30'd0, o_word}, {30'd0, 2'b01, 32'hA});
    chk("uc_ndig", {60'd0, o_ndigits}, 64'd1);
    @(negedge clk);
    // Bit 7 is not decoded
    send(8'hC1); send(8'hB3); send("E");
    chk("b7_word", {30'd0, o_word}, {30'd0, 2'b10, 32'h3});
    @(negedge clk);
    chk("b7_accepts", 64'(n_accept), 64'd8);
    $display("class edge cases done");

    // 6: "A12", reset pulse, then "E"
    send("A"); send("1"); send("2");
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_stb", {63'd0, o_stb}, 64'd0);
    chk("t6_rst_word", {30'd0, o_word}, 64'd0);
    chk("t6_rst_ndig", {60'd0, o_ndigits}, 64'd0);
    chk("t6_rst_code", {62'd0, o_err_code}, 64'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    send("E");
    chk("t6_err_nocmd", {63'd0, o_err}, 64'd1);
    chk("t6_code", {62'd0, o_err_code}, 64'd0);
    chk("t6_nostb", {63'd0, o_stb}, 64'd0);
    repeat (2) @(negedge clk);
    chk("t6_accepts", 64'(n_accept), 64'd8);
    $display("t6 reset mid-command done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
